// File: rtl/ipgen_memory_responder.sv
// On-chip RAM responder for the IPgen burst interface: accepts write bursts
// into a local synchronous RAM and answers read bursts from it, one at a time.
module ipgen_memory_responder #(
    parameter              NAME           = "undefined",
    parameter int          ID             = 0,
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          MEM_WORDS_LOG2 = 10
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    awvalid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic                    arvalid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    wlast_err
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int DEPTH  = 1 << MEM_WORDS_LOG2;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic                      prio_w;
    logic [MEM_WORDS_LOG2-1:0] idx;
    logic [7:0]                len;
    logic [8:0]                cnt;
    logic [DATA_WIDTH-1:0]     mem [DEPTH];
    logic [DATA_WIDTH-1:0]     fifo_data [2];
    logic                      fifo_last [2];
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic [1:0]                count;
    logic                      aw_hs;
    logic                      ar_hs;
    logic                      w_beat;
    logic                      final_beat;
    logic                      rd_issue;
    logic                      r_pop;
    logic                      unused_ok;

    function automatic logic [MEM_WORDS_LOG2-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
        return MEM_WORDS_LOG2'(a >> OFFS);
    endfunction

    assign unused_ok = ^{awaddr, araddr, NAME, ID};

    assign final_beat = (cnt == {1'b0, len});
    assign aw_hs      = awready;
    assign ar_hs      = arready;
    assign w_beat     = wvalid && wready;

    // FIFO head is the read port; rdata is masked so an empty FIFO shows zero
    assign rvalid = (count != 2'd0);
    assign rdata  = rvalid ? fifo_data[rd_ptr] : '0;
    assign rlast  = rvalid && fifo_last[rd_ptr];
    assign r_pop  = rvalid && rready;

    // Each issued RAM read lands directly in a FIFO slot, so there is never a
    // separate in-flight word; a slot is free when not full or being popped.
    assign rd_issue = (state == READ) && (cnt <= {1'b0, len}) && ((count < 2'd2) || r_pop);

    always_comb begin
        state_nxt = state;
        awready   = 1'b0;
        arready   = 1'b0;
        wready    = 1'b0;
        case (state)
            IDLE: begin
                awready = awvalid && (prio_w || !arvalid);
                arready = arvalid && (!prio_w || !awvalid);
                if (awready) begin
                    state_nxt = WRITE;
                end else if (arready) begin
                    state_nxt = READ;
                end
            end
            WRITE: begin
                wready = 1'b1;
                if (wvalid && final_beat) begin
                    state_nxt = IDLE;
                end
            end
            READ: begin
                if (r_pop && rlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Keep every handshake closed while reset is held
        if (RST) begin
            awready = 1'b0;
            arready = 1'b0;
            wready  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            prio_w    <= 1'b1;
            cnt       <= 9'd0;
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            wlast_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (aw_hs) begin
                prio_w <= 1'b0;
            end else if (ar_hs) begin
                prio_w <= 1'b1;
            end
            if (aw_hs || ar_hs) begin
                cnt <= 9'd0;
            end else if (w_beat || rd_issue) begin
                cnt <= cnt + 9'd1;
            end
            if (w_beat && (wlast != final_beat)) begin
                wlast_err <= 1'b1;
            end
            if (rd_issue) begin
                wr_ptr <= ~wr_ptr;
            end
            if (r_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(rd_issue) - 2'(r_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (aw_hs) begin
            idx <= word_index(awaddr);
            len <= awlen;
        end else if (ar_hs) begin
            idx <= word_index(araddr);
            len <= arlen;
        end else if (w_beat || rd_issue) begin
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_beat) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (rd_issue) begin
            fifo_data[wr_ptr] <= mem[idx];
            fifo_last[wr_ptr] <= final_beat;
        end
    end

endmodule

// File: tb/tb_ipgen_memory_responder.sv
// Directed bench for ipgen_memory_responder: table of write/read bursts plus
// hand-written reset, arbitration, backpressure and mid-burst reset sequences.
module tb_ipgen_memory_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        awvalid, awready, wlast, wvalid, wready;
    logic        arvalid, arready, rlast, rvalid, rready, wlast_err;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [3:0]  wstrb;

    int tests = 0;
    int fails = 0;

    ipgen_memory_responder #(
        .NAME("tb_ram"), .ID(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS_LOG2(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .wlast_err(wlast_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] base;
        logic [3:0]  strb;
        int          wlast_at;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] base, input logic [3:0] strb, input int wlast_at);
        logic got;
        @(negedge CLK);
        awvalid = 1'b1; awaddr = addr; awlen = len;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (awready) begin got = 1'b1; break; end
            @(negedge CLK);
        end
        check("aw_grant", got, 1);
        @(negedge CLK);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1; wdata = base + 32'(b); wstrb = strb; wlast = (b == wlast_at);
            #1 check("wready", wready, 1);
            @(negedge CLK);
        end
        wvalid = 1'b0; wlast = 1'b0;
        #1 check("w_idle", wready, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] base, input logic bp);
        logic        got, prev_stall, plast;
        logic [31:0] pdata;
        logic [5:0]  pat;
        int          beat, cyc;
        pat = 6'b101001;
        @(negedge CLK);
        arvalid = 1'b1; araddr = addr; arlen = len;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (arready) begin got = 1'b1; break; end
            @(negedge CLK);
        end
        check("ar_grant", got, 1);
        @(negedge CLK);
        arvalid = 1'b0;
        #1 check("r_lat1", rvalid, 0);
        beat = 0; cyc = 0; prev_stall = 1'b0; pdata = '0; plast = 1'b0;
        while (beat <= int'(len) && cyc < 200) begin
            @(negedge CLK);
            rready = bp ? pat[cyc % 6] : 1'b1;
            #1;
            if (cyc == 0) check("r_lat2", rvalid, 1);
            if (prev_stall) begin
                check("r_hold_data", rdata, pdata);
                check("r_hold_last", rlast, plast);
            end
            if (rvalid && rready) begin
                check("rdata", rdata, base + 32'(beat));
                check("rlast", rlast, beat == int'(len));
                beat++;
            end
            prev_stall = rvalid && !rready;
            pdata = rdata; plast = rlast;
            cyc++;
        end
        if (beat <= int'(len)) begin
            tests++; fails++;
            $display("FAIL r_timeout: got %0d beats expected %0d", beat, int'(len) + 1);
        end
        @(negedge CLK);
        rready = 1'b0;
        #1 check("r_done", rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        got, both, g_aw;
        logic [31:0] last_w;

        vecs[0] = '{1'b1, 32'h00, 8'd0, 32'hFFFF_FFFF, 4'hF, 0, 1'b0};
        vecs[1] = '{1'b1, 32'h00, 8'd0, 32'h1234_5678, 4'h5, 0, 1'b0};
        vecs[2] = '{1'b0, 32'h00, 8'd0, 32'hFF34_FF78, 4'h0, 0, 1'b0};
        vecs[3] = '{1'b1, 32'h10, 8'd3, 32'h0000_00A0, 4'hF, 3, 1'b0};
        vecs[4] = '{1'b0, 32'h10, 8'd3, 32'h0000_00A0, 4'h0, 0, 1'b0};
        vecs[5] = '{1'b1, 32'h38, 8'd3, 32'h0000_00C0, 4'hF, 2, 1'b1};
        vecs[6] = '{1'b0, 32'h38, 8'd3, 32'h0000_00C0, 4'h0, 0, 1'b1};
        vecs[7] = '{1'b0, 32'h00, 8'd0, 32'h0000_00C2, 4'h0, 0, 1'b1};

        // Reset with every input high
        RST = 1'b1;
        awvalid = 1'b1; awaddr = '1; awlen = '1; wdata = '1; wstrb = '1; wlast = 1'b1;
        wvalid = 1'b1; arvalid = 1'b1; araddr = '1; arlen = '1; rready = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            #1 check("reset_outs", {awready, wready, arready, rvalid, rlast, rdata, wlast_err}, 0);
        end

        // Release reset with both requests pending: grants must alternate
        @(negedge CLK);
        RST = 1'b0; awlen = 8'd0; arlen = 8'd0; awaddr = 32'h20; araddr = 32'h20;
        wvalid = 1'b0; wlast = 1'b0; wstrb = 4'hF; rready = 1'b1;
        #1 check("rst_release_aw", awready, 1);
        check("rst_release_ar", arready, 0);
        both = 1'b0; last_w = '0;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0; g_aw = 1'b0;
            for (int k = 0; k < 20; k++) begin
                #1;
                if (awready && arready) both = 1'b1;
                if (awready || arready) begin got = 1'b1; g_aw = awready; break; end
                @(negedge CLK);
            end
            check("arb_grant", {got, g_aw}, {1'b1, (g % 2 == 0)});
            @(negedge CLK);
            if (g_aw) begin
                wvalid = 1'b1; wdata = 32'h5A5A_0000 + 32'(g); wlast = 1'b1;
                last_w = wdata;
                #1 if (awready && arready) both = 1'b1;
                @(negedge CLK);
                wvalid = 1'b0; wlast = 1'b0;
            end else begin
                @(negedge CLK);
                #1 check("arb_rdata", {rvalid, rdata}, {1'b1, last_w});
                @(negedge CLK);
            end
        end
        check("arb_exclusive", both, 0);
        awvalid = 1'b0; arvalid = 1'b0; rready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr)
                do_write(vecs[i].addr, vecs[i].len, vecs[i].base, vecs[i].strb, vecs[i].wlast_at);
            else
                do_read(vecs[i].addr, vecs[i].len, vecs[i].base, 1'b0);
            check("wlast_err", wlast_err, vecs[i].exp_err);
        end

        // Backpressured 8-beat read
        do_write(32'h00, 8'd7, 32'h0000_00B0, 4'hF, 7);
        do_read(32'h00, 8'd7, 32'h0000_00B0, 1'b1);

        // Reset during beat 1 of a 4-beat read
        @(negedge CLK);
        arvalid = 1'b1; araddr = 32'h00; arlen = 8'd3; rready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (arready) begin got = 1'b1; break; end
            @(negedge CLK);
        end
        check("rst_ar_grant", got, 1);
        @(negedge CLK);
        arvalid = 1'b0;
        @(negedge CLK);
        #1 check("rst_beat0", {rvalid, rdata}, {1'b1, 32'h0000_00B0});
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        #1 check("rst_flush", rvalid, 0);
        check("rst_err_clear", wlast_err, 0);
        RST = 1'b0; rready = 1'b0;
        do_read(32'h00, 8'd3, 32'h0000_00B0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
